// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard controller bus: decoded D-stage operand/destination info in,
// stall and forward selects back out.
interface hazard_scoreboard_if #(
    parameter int unsigned TW   = 3,
    parameter int unsigned SELW = 2
);
    logic            d_valid;
    logic [4:0]      d_rs;
    logic [4:0]      d_rt;
    logic [TW-1:0]   d_tuse_rs;
    logic [TW-1:0]   d_tuse_rt;
    logic [4:0]      d_dst;
    logic [TW-1:0]   d_tnew;
    logic            d_md_start;
    logic            d_md_div;
    logic            d_md_use;
    logic            stall;
    logic [SELW-1:0] fwd_rs;
    logic [SELW-1:0] fwd_rt;
    logic            md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, fwd_rs, fwd_rt, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_dst, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, fwd_rs, fwd_rt, md_busy
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard scoreboard for the D stage: tracks in-flight destinations,
// derives stall and forward selects, and times mult/div HI/LO occupancy.
module hazard_scoreboard #(
    parameter int unsigned STAGES   = 3,
    parameter int unsigned TW       = 3,
    parameter int unsigned SELW     = 2,
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
);
    localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] TUSE_NONE = {TW{1'b1}};

    logic [STAGES-1:0]          v_q, v_d;
    logic [STAGES-1:0][4:0]     dst_q, dst_d;
    logic [STAGES-1:0][TW-1:0]  tnew_q, tnew_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       md_busy_q, md_busy_d;

    logic                       hit_rs, hit_rt;
    logic [TW-1:0]              mt_rs, mt_rt;
    logic [SELW-1:0]            sel_rs, sel_rt;
    logic                       stall_rs, stall_rt, md_stall, stall_c;

    // Youngest match wins: scan oldest to youngest so lower k overwrites.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        mt_rs  = '0;
        mt_rt  = '0;
        sel_rs = '0;
        sel_rt = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            if (hz.d_rs != 5'd0 && v_q[k] && dst_q[k] == hz.d_rs) begin
                hit_rs = 1'b1;
                mt_rs  = tnew_q[k];
                sel_rs = SELW'(k + 1);
            end
            if (hz.d_rt != 5'd0 && v_q[k] && dst_q[k] == hz.d_rt) begin
                hit_rt = 1'b1;
                mt_rt  = tnew_q[k];
                sel_rt = SELW'(k + 1);
            end
        end
    end

    always_comb begin
        stall_rs = hit_rs && (hz.d_tuse_rs != TUSE_NONE) && (mt_rs > hz.d_tuse_rs);
        stall_rt = hit_rt && (hz.d_tuse_rt != TUSE_NONE) && (mt_rt > hz.d_tuse_rt);
        md_stall = hz.d_md_use && md_busy_q;
        stall_c  = hz.d_valid && (stall_rs || stall_rt || md_stall);
    end

    // Shift the scoreboard one stage, saturating Tnew at zero; a stall injects a bubble.
    always_comb begin
        v_d    = '0;
        dst_d  = '0;
        tnew_d = '0;
        v_d[0]    = hz.d_valid && !stall_c && (hz.d_dst != 5'd0);
        dst_d[0]  = hz.d_dst;
        tnew_d[0] = hz.d_tnew;
        for (int k = 1; k < int'(STAGES); k++) begin
            v_d[k]    = v_q[k-1];
            dst_d[k]  = dst_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
    end

    // Mult/div occupancy keeps counting down even while D is frozen.
    always_comb begin
        cnt_d = cnt_q;
        if (hz.d_md_start && hz.d_valid && !stall_c) begin
            cnt_d = hz.d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        md_busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q       <= '0;
            dst_q     <= '0;
            tnew_q    <= '0;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
        end else begin
            v_q       <= v_d;
            dst_q     <= dst_d;
            tnew_q    <= tnew_d;
            cnt_q     <= cnt_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign hz.stall   = stall_c;
    assign hz.fwd_rs  = (hit_rs && mt_rs == '0) ? sel_rs : '0;
    assign hz.fwd_rt  = (hit_rt && mt_rt == '0) ? sel_rt : '0;
    assign hz.md_busy = md_busy_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed pipeline scenarios plus a
// random instruction stream checked against an issue-history reference model.
module tb_hazard_scoreboard;
    localparam int STAGES   = 3;
    localparam int TW       = 3;
    localparam int SELW     = 2;
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int NC       = 8192;

    typedef struct {
        bit   valid;
        int   rs, rt, tuse_rs, tuse_rt, dst, tnew;
        bit   md_start, md_div, md_use;
    } in_t;

    typedef struct {
        bit stall;
        int fwd_rs, fwd_rt;
        bit md_busy;
        int cyc;
    } exp_t;

    logic clk;
    logic reset;
    hazard_scoreboard_if #(.TW(TW), .SELW(SELW)) hz ();

    hazard_scoreboard #(
        .STAGES(STAGES), .TW(TW), .SELW(SELW),
        .MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of what entered E each cycle, plus mult/div end cycle.
    bit   hv [NC];
    int   hd [NC];
    int   ht [NC];
    int   cyc;
    int   rst_base;
    int   md_until;

    exp_t exp_q[$];
    exp_t me;
    int   checks;
    int   failures;

    function automatic void lookup(input int r, output bit hit, output int rem, output int age);
        int c;
        hit = 1'b0; rem = 0; age = 0;
        if (r == 0) return;
        for (int k = 0; k < STAGES; k++) begin
            c = cyc - 1 - k;
            if (!hit && c >= rst_base && c >= 0 && hv[c] && hd[c] == r) begin
                hit = 1'b1;
                age = k;
                rem = (ht[c] > k) ? ht[c] - k : 0;
            end
        end
    endfunction

    function automatic exp_t model_eval(input in_t in);
        exp_t e;
        bit hrs, hrt, srs, srt;
        int rrs, rrt, ars, art;
        lookup(in.rs, hrs, rrs, ars);
        lookup(in.rt, hrt, rrt, art);
        srs = hrs && in.tuse_rs != 7 && rrs > in.tuse_rs;
        srt = hrt && in.tuse_rt != 7 && rrt > in.tuse_rt;
        e.md_busy = (cyc <= md_until);
        e.stall   = in.valid && (srs || srt || (in.md_use && e.md_busy));
        e.fwd_rs  = (hrs && rrs == 0) ? ars + 1 : 0;
        e.fwd_rt  = (hrt && rrt == 0) ? art + 1 : 0;
        e.cyc     = cyc;
        return e;
    endfunction

    function automatic void model_commit(input in_t in, input bit stall);
        bit issue;
        issue   = in.valid && !stall;
        hv[cyc] = issue && in.dst != 0;
        hd[cyc] = in.dst;
        ht[cyc] = in.tnew;
        if (issue && in.md_start) md_until = cyc + (in.md_div ? DIV_CYC : MULT_CYC);
        cyc++;
    endfunction

    function automatic in_t mk(input bit v, input int rs, input int rt, input int trs,
                               input int trt, input int dst, input int tnew,
                               input bit ms = 1'b0, input bit md = 1'b0, input bit mu = 1'b0);
        in_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.tuse_rs = trs; i.tuse_rt = trt;
        i.dst = dst; i.tnew = tnew; i.md_start = ms; i.md_div = md; i.md_use = mu;
        return i;
    endfunction

    task automatic apply(input in_t in);
        hz.d_valid    = in.valid;
        hz.d_rs       = 5'(in.rs);
        hz.d_rt       = 5'(in.rt);
        hz.d_tuse_rs  = 3'(in.tuse_rs);
        hz.d_tuse_rt  = 3'(in.tuse_rt);
        hz.d_dst      = 5'(in.dst);
        hz.d_tnew     = 3'(in.tnew);
        hz.d_md_start = in.md_start;
        hz.d_md_div   = in.md_div;
        hz.d_md_use   = in.md_use;
    endtask

    // Called #1 after a rising edge; drives one D-stage cycle.
    task automatic step(input in_t in);
        exp_t e;
        apply(in);
        e = model_eval(in);
        exp_q.push_back(e);
        @(posedge clk);
        model_commit(in, e.stall);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs checked while reset is high.
    task automatic do_reset(input in_t in);
        exp_t e;
        reset    = 1'b1;
        rst_base = cyc;
        md_until = -1;
        apply(in);
        e = model_eval(in);
        exp_q.push_back(e);
        @(posedge clk);
        hv[cyc] = 1'b0;
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 0, 0, 7, 7, 0, 0));
    endtask

    function automatic in_t rand_in();
        in_t i;
        int  t, r;
        i.valid   = ($urandom % 8) != 0;
        i.rs      = $urandom % 8;
        i.rt      = $urandom % 8;
        t         = $urandom % 5;
        i.tuse_rs = (t == 4) ? 7 : t;
        t         = $urandom % 5;
        i.tuse_rt = (t == 4) ? 7 : t;
        i.dst     = $urandom % 8;
        i.tnew    = $urandom % 4;
        r         = $urandom % 16;
        i.md_start = (r == 0);
        i.md_div   = $urandom % 2;
        i.md_use   = (r < 3);
        return i;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            checks++;
            if (hz.stall !== me.stall) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%0b exp=%0b", me.cyc, hz.stall, me.stall);
            end
            checks++;
            if (hz.fwd_rs !== 2'(me.fwd_rs)) begin
                failures++;
                $display("FAIL fwd_rs cyc=%0d got=%0d exp=%0d", me.cyc, hz.fwd_rs, me.fwd_rs);
            end
            checks++;
            if (hz.fwd_rt !== 2'(me.fwd_rt)) begin
                failures++;
                $display("FAIL fwd_rt cyc=%0d got=%0d exp=%0d", me.cyc, hz.fwd_rt, me.fwd_rt);
            end
            checks++;
            if (hz.md_busy !== me.md_busy) begin
                failures++;
                $display("FAIL md_busy cyc=%0d got=%0b exp=%0b", me.cyc, hz.md_busy, me.md_busy);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rst_base = 0;
        md_until = -1;
        reset    = 1'b1;
        apply(mk(0, 0, 0, 7, 7, 0, 0));
        @(posedge clk);
        #1;
        // Reset state with a hazard-looking D instruction present.
        do_reset(mk(1, 8, 9, 0, 0, 8, 2, 1'b0, 1'b0, 1'b1));

        // Load-use: lw r8 Tnew=2, then add rs=r8 Tuse=1.
        step(mk(1, 0, 0, 7, 7, 8, 2));
        step(mk(1, 8, 0, 1, 7, 3, 0));
        step(mk(1, 8, 0, 1, 7, 3, 0));
        drain(4);

        // Branch: ori r9 Tnew=1, then beq rs=r9 Tuse=0.
        step(mk(1, 0, 0, 7, 7, 9, 1));
        step(mk(1, 9, 0, 0, 7, 0, 0));
        step(mk(1, 9, 0, 0, 7, 0, 0));
        drain(4);

        // Writes to $0 never create entries.
        step(mk(1, 0, 0, 7, 7, 0, 0));
        step(mk(1, 0, 0, 0, 0, 4, 0));
        drain(4);

        // Youngest producer wins: addu r5 then lw r5, consumer rs=r5 Tuse=1.
        step(mk(1, 0, 0, 7, 7, 5, 0));
        step(mk(1, 0, 0, 7, 7, 5, 2));
        step(mk(1, 5, 5, 1, 7, 6, 0));
        step(mk(1, 5, 5, 1, 7, 6, 0));
        drain(4);

        // mult then mfhi held while busy; then div.
        step(mk(1, 0, 0, 7, 7, 0, 0, 1'b1, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) step(mk(1, 0, 0, 7, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        step(mk(1, 0, 0, 7, 7, 0, 0, 1'b1, 1'b1, 1'b1));
        for (int i = 0; i < 12; i++) step(mk(1, 0, 0, 7, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        drain(2);

        // Reset while mfhi is stalled on a running mult.
        step(mk(1, 0, 0, 7, 7, 7, 0));
        step(mk(1, 0, 0, 7, 7, 0, 0, 1'b1, 1'b0, 1'b1));
        step(mk(1, 0, 0, 7, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        step(mk(1, 0, 0, 7, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        do_reset(mk(1, 7, 0, 0, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        step(mk(1, 7, 0, 0, 7, 2, 0, 1'b0, 1'b0, 1'b1));
        step(mk(1, 7, 0, 0, 7, 2, 0, 1'b0, 1'b0, 1'b1));

        // Random instruction stream with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            if (($urandom % 400) == 0) do_reset(rand_in());
            else                       step(rand_in());
        end
        drain(2);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
